// File: rtl/bsg_thermometer_occupancy.sv
// Occupancy/credit tracker holding its state as a thermometer code, with a registered
// binary count and full/empty/threshold flags so no output depends combinationally on an input.
module bsg_thermometer_occupancy #(
    parameter  int width_p  = 32,
    parameter  int thresh_p = 16,
    localparam int lg_w     = $clog2(width_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               inc_v_i,
    output logic               inc_ready_o,
    input  logic               dec_v_i,
    output logic               dec_ready_o,
    input  logic               load_v_i,
    input  logic [lg_w-1:0]    load_count_i,
    output logic [width_p-1:0] thermo_o,
    output logic [lg_w-1:0]    count_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               above_thresh_o
);

    if (width_p < 2) begin : g_bad_width
        $error("bsg_thermometer_occupancy: width_p must be at least 2");
    end
    if (thresh_p < 1 || thresh_p > width_p) begin : g_bad_thresh
        $error("bsg_thermometer_occupancy: thresh_p must lie in 1..width_p");
    end

    localparam logic [lg_w-1:0] MaxCount = lg_w'(width_p);

    logic [width_p-1:0] thermo_q, thermo_d;
    logic [lg_w-1:0]    count_q,  count_d;
    logic               full_q,   full_d;
    logic               empty_q,  empty_d;
    logic               above_q,  above_d;

    logic               inc_acc, dec_acc;
    logic [lg_w-1:0]    load_sat;
    logic [width_p-1:0] thermo_ld;

    // Ready is taken from the flag flops, so acceptance never chains through the request inputs.
    assign inc_acc = inc_v_i & ~full_q;
    assign dec_acc = dec_v_i & ~empty_q;

    assign load_sat = (load_count_i > MaxCount) ? MaxCount : load_count_i;

    always_comb begin
        thermo_ld = '0;
        for (int unsigned i = 0; i < width_p; i++) begin
            thermo_ld[i] = (lg_w'(i) < load_sat);
        end
    end

    always_comb begin
        thermo_d = thermo_q;
        count_d  = count_q;
        if (load_v_i) begin
            thermo_d = thermo_ld;
            count_d  = load_sat;
        end else if (inc_acc && dec_acc) begin
            thermo_d = thermo_q;
            count_d  = count_q;
        end else if (inc_acc) begin
            thermo_d = {thermo_q[width_p-2:0], 1'b1};
            count_d  = count_q + lg_w'(1);
        end else if (dec_acc) begin
            thermo_d = {1'b0, thermo_q[width_p-1:1]};
            count_d  = count_q - lg_w'(1);
        end
    end

    // Flags come from the next-state thermometer so they land in the same cycle as the count.
    always_comb begin
        full_d  = thermo_d[width_p-1];
        empty_d = ~thermo_d[0];
        above_d = thermo_d[thresh_p-1];
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            thermo_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            above_q  <= 1'b0;
        end else begin
            thermo_q <= thermo_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            above_q  <= above_d;
        end
    end

    assign thermo_o       = thermo_q;
    assign count_o        = count_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign above_thresh_o = above_q;
    assign inc_ready_o    = ~full_q;
    assign dec_ready_o    = ~empty_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (((thermo_q + width_p'(1)) & thermo_q) == '0)
                else $error("thermo_o is not a thermometer code: %h", thermo_q);
            assert ($countones(thermo_q) == int'(count_q))
                else $error("count_o %0d disagrees with popcount(thermo_o)", count_q);
            assert (full_q == thermo_q[width_p-1])
                else $error("full_o disagrees with thermo_o");
            assert (empty_q == ~thermo_q[0])
                else $error("empty_o disagrees with thermo_o");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_thermometer_occupancy.sv
// Directed-vector bench for bsg_thermometer_occupancy at width 32 plus a long random run
// of both the 32-wide and a 5-wide instance against a small occupancy model.
module tb_bsg_thermometer_occupancy;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 32-wide instance (default parameters)
    logic        rst_n, inc_v, dec_v, load_v;
    logic [5:0]  load_cnt;
    logic        inc_rdy, dec_rdy, full, empty, above;
    logic [31:0] thermo;
    logic [5:0]  count;

    bsg_thermometer_occupancy u_dut (
        .clk_i          (clk),
        .reset_n_i      (rst_n),
        .inc_v_i        (inc_v),
        .inc_ready_o    (inc_rdy),
        .dec_v_i        (dec_v),
        .dec_ready_o    (dec_rdy),
        .load_v_i       (load_v),
        .load_count_i   (load_cnt),
        .thermo_o       (thermo),
        .count_o        (count),
        .full_o         (full),
        .empty_o        (empty),
        .above_thresh_o (above)
    );

    // 5-wide instance, threshold 5
    logic        rst5_n, inc5_v, dec5_v, load5_v;
    logic [2:0]  load5_cnt;
    logic        inc5_rdy, dec5_rdy, full5, empty5, above5;
    logic [4:0]  thermo5;
    logic [2:0]  count5;

    bsg_thermometer_occupancy #(.width_p(5), .thresh_p(5)) u_dut5 (
        .clk_i          (clk),
        .reset_n_i      (rst5_n),
        .inc_v_i        (inc5_v),
        .inc_ready_o    (inc5_rdy),
        .dec_v_i        (dec5_v),
        .dec_ready_o    (dec5_rdy),
        .load_v_i       (load5_v),
        .load_count_i   (load5_cnt),
        .thermo_o       (thermo5),
        .count_o        (count5),
        .full_o         (full5),
        .empty_o        (empty5),
        .above_thresh_o (above5)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_thermo(input int occ);
        logic [63:0] t;
        t = (64'd1 << occ) - 64'd1;
        return t[31:0];
    endfunction

    function automatic int model_next(input int occ, input int w, input logic inc, input logic dec,
                                      input logic ld, input int lc);
        logic ia, da;
        if (ld) return (lc > w) ? w : lc;
        ia = inc && (occ < w);
        da = dec && (occ > 0);
        if (ia && da) return occ;
        if (ia) return occ + 1;
        if (da) return occ - 1;
        return occ;
    endfunction

    task automatic check_all32(input string tag, input int occ);
        check_vec({tag, ".count"},  32'(count),  32'(occ));
        check_vec({tag, ".thermo"}, thermo,      model_thermo(occ));
        check_vec({tag, ".full"},   32'(full),   32'(occ == 32));
        check_vec({tag, ".empty"},  32'(empty),  32'(occ == 0));
        check_vec({tag, ".above"},  32'(above),  32'(occ >= 16));
        check_vec({tag, ".incrdy"}, 32'(inc_rdy), 32'(occ != 32));
        check_vec({tag, ".decrdy"}, 32'(dec_rdy), 32'(occ != 0));
        check_vec({tag, ".popcnt"}, 32'($countones(thermo)), 32'(occ));
    endtask

    task automatic check_all5(input string tag, input int occ);
        check_vec({tag, ".count"},  32'(count5),  32'(occ));
        check_vec({tag, ".thermo"}, 32'(thermo5), model_thermo(occ));
        check_vec({tag, ".full"},   32'(full5),   32'(occ == 5));
        check_vec({tag, ".empty"},  32'(empty5),  32'(occ == 0));
        check_vec({tag, ".above"},  32'(above5),  32'(occ >= 5));
        check_vec({tag, ".incrdy"}, 32'(inc5_rdy), 32'(occ != 5));
        check_vec({tag, ".decrdy"}, 32'(dec5_rdy), 32'(occ != 0));
        check_vec({tag, ".popcnt"}, 32'($countones(thermo5)), 32'(occ));
    endtask

    initial begin
        int occ32, occ5, lc;

        rst_n  = 1'b0; inc_v  = 1'b0; dec_v  = 1'b0; load_v  = 1'b0; load_cnt  = '0;
        rst5_n = 1'b0; inc5_v = 1'b0; dec5_v = 1'b0; load5_v = 1'b0; load5_cnt = '0;

        // Reset state
        step();
        check_all32("reset", 0);

        // 32 back-to-back increments up to full
        rst_n = 1'b1;
        inc_v = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            step();
            check_all32($sformatf("inc%0d", i), i);
        end
        check_vec("fill.thermo_all_ones", thermo, 32'hFFFF_FFFF);

        // Full boundary: inc+dec gives only the decrement
        dec_v = 1'b1;
        step();
        check_vec("full_incdec.count", 32'(count), 32'd31);
        check_vec("full_incdec.thermo", thermo, 32'h7FFF_FFFF);

        // Empty boundary: inc+dec gives only the increment
        inc_v = 1'b0; dec_v = 1'b0;
        load_v = 1'b1; load_cnt = 6'd0;
        step();
        check_all32("load0", 0);
        load_v = 1'b0;
        inc_v = 1'b1; dec_v = 1'b1;
        step();
        check_vec("empty_incdec.count", 32'(count), 32'd1);
        check_vec("empty_incdec.thermo", thermo, 32'h1);

        // Simultaneous inc+dec at count 5 holds
        inc_v = 1'b0; dec_v = 1'b0;
        load_v = 1'b1; load_cnt = 6'd5;
        step();
        load_v = 1'b0;
        inc_v = 1'b1; dec_v = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_vec($sformatf("hold%0d.count", i), 32'(count), 32'd5);
            check_vec($sformatf("hold%0d.thermo", i), thermo, 32'h1F);
        end

        // Saturating load overrides a decrement
        inc_v = 1'b0; dec_v = 1'b0;
        load_v = 1'b1; load_cnt = 6'd3;
        step();
        check_all32("load3", 3);
        dec_v = 1'b1; load_cnt = 6'd40;
        step();
        check_all32("load40", 32);
        dec_v = 1'b0; load_cnt = 6'd0;
        step();
        check_all32("load0b", 0);
        load_v = 1'b0;

        // Reset mid-stream at count 20 with inc asserted
        load_v = 1'b1; load_cnt = 6'd20;
        step();
        check_all32("load20", 20);
        load_v = 1'b0;
        inc_v = 1'b1; rst_n = 1'b0;
        step();
        check_all32("midreset", 0);
        inc_v = 1'b0;
        step();
        check_all32("midreset_hold", 0);
        rst_n = 1'b1;

        // Random run on both instances
        check_all5("reset5", 0);
        rst5_n = 1'b1;
        occ32 = 0;
        occ5  = 0;
        for (int n = 0; n < 10000; n++) begin
            inc_v  = 1'($urandom_range(0, 1));
            dec_v  = 1'($urandom_range(0, 1));
            load_v = ($urandom_range(0, 15) == 0);
            lc     = int'($urandom_range(0, 63));
            load_cnt = 6'(lc);
            occ32  = model_next(occ32, 32, inc_v, dec_v, load_v, lc);

            inc5_v  = 1'($urandom_range(0, 1));
            dec5_v  = 1'($urandom_range(0, 1));
            load5_v = ($urandom_range(0, 15) == 0);
            lc      = int'($urandom_range(0, 7));
            load5_cnt = 3'(lc);
            occ5    = model_next(occ5, 5, inc5_v, dec5_v, load5_v, lc);

            step();
            check_all32("rnd32", occ32);
            check_all5("rnd5", occ5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
